// File: rtl/oops_pkg.sv
// Shared definitions for the SPI command slave datapath.
//   CMD_READ / CMD_WRITE : two-bit SPI opcodes decoded upstream
//   ADDR_W / DATA_W      : external asynchronous SRAM geometry
//   sram_seq_state_t     : phase of one timed SRAM access
//   max3()               : helper for sizing phase counters
package oops_pkg;

   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_WRITE = 2'b11;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } sram_seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sram_access_seq.sv
// sram_access_seq
//   Takes one decoded SPI command per valid/ready handshake and runs a timed
//   asynchronous-SRAM cycle: SETUP (address + cen), PULSE (oen or wen low),
//   HOLD (strobe released, cen still low), then back to IDLE. Read data is
//   returned with a one-cycle rsp_valid pulse in the first IDLE cycle.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready          command handshake (ready only in IDLE, not in reset)
//   cmd_write/addr/wdata     command fields, captured on accept
//   rsp_valid/rsp_rdata      read response (pulse / held data)
//   busy                     access in progress
//   sram_cen/oen/wen         active-low SRAM strobes (registered)
//   sram_addr                SRAM address, held after the access
//   sram_dq_o/sram_dq_oe     write data and pad drive enable (registered)
//   sram_dq_i                data from the SRAM pad
module sram_access_seq #(
   parameter int ADDR_W    = oops_pkg::ADDR_W,
   parameter int DATA_W    = oops_pkg::DATA_W,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              sram_cen,
   output logic              sram_oen,
   output logic              sram_wen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_i
);

   import oops_pkg::*;

   localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);

   if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_cyc_check
      $error("sram_access_seq: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
   end

   sram_seq_state_t  state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             wr_q, wr_nxt;
   logic             accept, last;
   logic             cen_d, oen_d, wen_d, dq_oe_d, rsp_valid_d, rd_sample;

   assign cmd_ready = (state == IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE);
   assign last      = (cnt == CNT_W'(1));

   // Next state: the phase counter reloads on every state entry and the
   // phase ends when it reaches 1.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt - CNT_W'(1);
      case (state)
         IDLE: begin
            cnt_nxt = cnt;
            if (accept) begin
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
            end
         end
         SETUP: if (last) begin
            state_nxt = PULSE;
            cnt_nxt   = PULSE_LD;
         end
         PULSE: if (last) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LD;
         end
         HOLD: if (last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Output decode from the upcoming state, so the registered strobes line
   // up with the state they belong to. On an accept the direction comes
   // straight from the command, otherwise from the captured copy.
   always_comb begin
      wr_nxt      = accept ? cmd_write : wr_q;
      cen_d       = (state_nxt == IDLE);
      wen_d       = !((state_nxt == PULSE) && wr_nxt);
      oen_d       = !((state_nxt == PULSE) && !wr_nxt);
      dq_oe_d     = (state_nxt != IDLE) && wr_nxt;
      rd_sample   = (state == PULSE) && last && !wr_q;
      rsp_valid_d = (state == HOLD) && last && !wr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         wr_q       <= 1'b0;
         sram_cen   <= 1'b1;
         sram_oen   <= 1'b1;
         sram_wen   <= 1'b1;
         sram_dq_oe <= 1'b0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sram_cen   <= cen_d;
         sram_oen   <= oen_d;
         sram_wen   <= wen_d;
         sram_dq_oe <= dq_oe_d;
         rsp_valid  <= rsp_valid_d;
         if (accept) begin
            wr_q      <= cmd_write;
            sram_addr <= cmd_addr;
            if (cmd_write) sram_dq_o <= cmd_wdata;
         end
         // Data is taken while oen is still low, at the end of the strobe.
         if (rd_sample) rsp_rdata <= sram_dq_i;
      end
   end

endmodule

// File: tb/tb_sram_access_seq.sv
module tb_sram_access_seq;

   localparam int S = 1;
   localparam int P = 2;
   localparam int H = 1;
   localparam int T = S + P + H;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_write, cmd_ready;
   logic [16:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid, busy;
   logic [7:0]  rsp_rdata;
   logic        sram_cen, sram_oen, sram_wen, sram_dq_oe;
   logic [16:0] sram_addr;
   logic [7:0]  sram_dq_o;
   logic [7:0]  sram_dq_i = 8'hee;

   // second instance with stretched timing 2/3/2
   logic        c6_valid, c6_write, c6_ready;
   logic [16:0] c6_addr;
   logic [7:0]  c6_wdata;
   logic        r6_valid, busy6;
   logic [7:0]  r6_rdata;
   logic        cen6, oen6, wen6, oe6;
   logic [16:0] addr6;
   logic [7:0]  dqo6;
   logic [7:0]  dqi6 = 8'hee;

   always #5 clk = ~clk;

   sram_access_seq u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .sram_cen(sram_cen), .sram_oen(sram_oen), .sram_wen(sram_wen),
      .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
      .sram_dq_i(sram_dq_i)
   );

   sram_access_seq #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut6 (
      .clk(clk), .rst(rst),
      .cmd_valid(c6_valid), .cmd_ready(c6_ready), .cmd_write(c6_write),
      .cmd_addr(c6_addr), .cmd_wdata(c6_wdata),
      .rsp_valid(r6_valid), .rsp_rdata(r6_rdata), .busy(busy6),
      .sram_cen(cen6), .sram_oen(oen6), .sram_wen(wen6),
      .sram_addr(addr6), .sram_dq_o(dqo6), .sram_dq_oe(oe6),
      .sram_dq_i(dqi6)
   );

   // Behavioural asynchronous SRAM: writes while cen/wen low with the bus
   // driven, read data presented while cen/oen low, junk otherwise.
   logic [7:0] sram_mem [int];

   always @(posedge clk)
      if (!sram_cen && !sram_wen && sram_dq_oe) sram_mem[int'(sram_addr)] = sram_dq_o;

   always @(negedge clk) begin
      if (!sram_cen && !sram_oen)
         sram_dq_i <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 8'h00;
      else
         sram_dq_i <= 8'hee;
      dqi6 <= (!cen6 && !oen6) ? (addr6[7:0] ^ 8'h5a) : 8'hee;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Command-level reference: what each address should hold.
   logic [7:0] ref_mem [int];
   logic [7:0] last_rd;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] ctl();
      return {sram_cen, sram_oen, sram_wen, sram_dq_oe, busy, rsp_valid, cmd_ready};
   endfunction

   function automatic logic [6:0] ctl6();
      return {cen6, oen6, wen6, oe6, busy6, r6_valid, c6_ready};
   endfunction

   // Present a command (called just after a falling edge) and wait for the
   // accepting rising edge. With keep set, cmd_valid stays high afterwards.
   task automatic accept_cmd(input bit wr, input logic [16:0] a, input logic [7:0] d,
                             input bit keep, output int acc_cyc);
      int n;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
         cmd_valid = 1'b0;
         acc_cyc   = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      if (!keep) begin
         cmd_valid = 1'b0;
         cmd_write = ~wr;
         cmd_addr  = ~a;
         cmd_wdata = ~d;
      end
   endtask

   // Check every cycle of the access against the timing rules, from the
   // first SETUP cycle through the first IDLE cycle.
   task automatic check_window(input bit wr, input logic [16:0] a, input logic [7:0] d,
                               input logic [7:0] exp_rd, input int pulse_k);
      logic [6:0] e;
      bit in_p;
      for (int k = 1; k <= T + 1; k++) begin
         @(negedge clk);
         in_p = (k > S) && (k <= S + P);
         e = {!(k <= T), !(in_p && !wr), !(in_p && wr), (k <= T) && wr,
              (k <= T), (k == T + 1) && !wr, (k == T + 1)};
         chk($sformatf("ctl %s k=%0d", wr ? "wr" : "rd", k), ctl(), e);
         chk($sformatf("addr k=%0d", k), sram_addr, a);
         if (wr && k <= T) chk($sformatf("dq_o k=%0d", k), sram_dq_o, d);
         if (k == T + 1) chk(wr ? "rdata_held" : "rdata", rsp_rdata, wr ? last_rd : exp_rd);
         if (k == pulse_k) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 17'h1ffff;
         end else if (pulse_k != 0 && k == pulse_k + 1) begin
            cmd_valid = 1'b0;
         end
      end
   endtask

   task automatic run_cmd(input bit wr, input logic [16:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input bit keep, input int pulse_k,
                          output int acc_cyc);
      accept_cmd(wr, a, d, keep, acc_cyc);
      if (acc_cyc < 0) return;
      if (wr) ref_mem[int'(a)] = d;
      check_window(wr, a, d, exp_rd, pulse_k);
      if (!wr) last_rd = exp_rd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle ctl", ctl(), 7'b1110001);
      end
   endtask

   function automatic logic [7:0] ref_rd(input logic [16:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
   endfunction

   typedef struct {
      bit          wr;
      logic [16:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int acc, acc2, prev_acc;
      bit wr, keep, prev_keep;
      logic [16:0] a;
      logic [7:0] d;

      vecs[0] = '{1'b1, 17'h139c6, 8'h9c, 8'h00};
      vecs[1] = '{1'b0, 17'h139c6, 8'h00, 8'h9c};
      vecs[2] = '{1'b1, 17'h00abc, 8'h3e, 8'h00};
      vecs[3] = '{1'b1, 17'h1ffff, 8'ha5, 8'h00};
      vecs[4] = '{1'b0, 17'h00abc, 8'h00, 8'h3e};
      vecs[5] = '{1'b0, 17'h1ffff, 8'h00, 8'ha5};
      vecs[6] = '{1'b0, 17'h00777, 8'h00, 8'h00};
      vecs[7] = '{1'b1, 17'h139c6, 8'h61, 8'h00};
      vecs[8] = '{1'b0, 17'h139c6, 8'h00, 8'h61};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      c6_valid = 1'b0;  c6_write = 1'b0;  c6_addr = '0;  c6_wdata = '0;
      last_rd = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      chk("reset ctl", ctl(), 7'b1110000);
      chk("reset addr", sram_addr, 17'h0);
      chk("reset dq_o", sram_dq_o, 8'h00);
      chk("reset rdata", rsp_rdata, 8'h00);
      chk("reset ctl6", ctl6(), 7'b1110000);
      rst = 1'b0;
      #1;
      chk("ready after reset", ctl(), 7'b1110001);

      // table-driven accesses with one idle cycle between them
      foreach (vecs[i]) begin
         run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0, 0, acc);
         idle(1);
      end

      // back-to-back with cmd_valid held high: second accept exactly T+1 later
      run_cmd(1'b1, 17'h00001, 8'h55, 8'h00, 1'b1, 0, acc);
      run_cmd(1'b0, 17'h00001, 8'h00, 8'h55, 1'b0, 0, acc2);
      chk("b2b spacing", acc2 - acc, T + 1);
      idle(1);

      // command pulsed while busy is ignored
      run_cmd(1'b1, 17'h00002, 8'hc3, 8'h00, 1'b0, 2, acc);
      idle(3);
      chk("busy pulse addr", sram_addr, 17'h00002);

      // reset in the middle of a read
      accept_cmd(1'b0, 17'h139c6, 8'h00, 1'b0, acc);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort ctl", ctl(), 7'b1110000);
      chk("abort addr", sram_addr, 17'h0);
      rst = 1'b0;
      last_rd = 8'h00;
      idle(8);
      run_cmd(1'b0, 17'h139c6, 8'h00, 8'h61, 1'b0, 0, acc);
      idle(1);

      // stretched timing instance: write then read of address 5
      for (int w = 1; w >= 0; w--) begin
         @(negedge clk);
         c6_valid = 1'b1;
         c6_write = w[0];
         c6_addr  = 17'h00005;
         c6_wdata = 8'h77;
         chk("t6 ready", c6_ready, 1'b1);
         @(posedge clk);
         #1;
         c6_valid = 1'b0;
         c6_addr  = 17'h0;
         for (int k = 1; k <= 9; k++) begin
            logic [6:0] e;
            bit in_p;
            @(negedge clk);
            in_p = (k >= 3) && (k <= 5);
            e = {!(k <= 7), !(in_p && w == 0), !(in_p && w == 1), (k <= 7) && w == 1,
                 (k <= 7), (k == 8) && w == 0, (k >= 8)};
            chk($sformatf("t6 ctl w=%0d k=%0d", w, k), ctl6(), e);
            if (w == 1 && k <= 7) chk("t6 dq_o", dqo6, 8'h77);
            if (w == 0 && k == 8) chk("t6 rdata", r6_rdata, 8'h5f);
         end
      end

      // randomized traffic against the command-level model
      prev_keep = 1'b0;
      prev_acc  = 0;
      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom_range(0, 1));
         a    = 17'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) a = a | 17'h1fff8;
         d    = 8'($urandom);
         keep = (i != 39) && ($urandom_range(0, 3) == 0);
         run_cmd(wr, a, d, wr ? 8'h00 : ref_rd(a), keep, 0, acc);
         if (prev_keep) chk("rand b2b spacing", acc - prev_acc, T + 1);
         prev_keep = keep;
         prev_acc  = acc;
         if (!keep) idle($urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
